// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT output.
module sync_fifo #(
    parameter int unsigned data_width          = 8,
    parameter int unsigned fifo_depth          = 32,
    parameter int unsigned addr_width          = $clog2(fifo_depth),
    parameter bit          fwft                = 1'b0,
    parameter int unsigned almost_full_thresh  = fifo_depth - 4,
    parameter int unsigned almost_empty_thresh = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [data_width-1:0] din,
    input  logic                  rd_en,
    output logic [data_width-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned cnt_width = addr_width + 1;

    logic [data_width-1:0] mem [fifo_depth];
    logic [addr_width:0]   wr_ptr;
    logic [addr_width:0]   rd_ptr;
    logic                  valid;
    logic                  valid_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_rd;
    logic                  mem_has;
    logic [addr_width:0]   count_nxt;

    // Accept/pop decisions and next occupancy; clr wins over both requests.
    always_comb begin
        wr_acc    = wr_en & ~full & ~clr;
        rd_acc    = rd_en & ~empty & ~clr;
        mem_has   = (wr_ptr != rd_ptr);
        mem_rd    = rd_acc;
        valid_nxt = valid;
        count_nxt = count;
        if (fwft) begin
            // Refill the output register whenever it is free or being popped.
            mem_rd = mem_has & (~valid | rd_acc) & ~clr;
            if (mem_rd) begin
                valid_nxt = 1'b1;
            end else if (rd_acc) begin
                valid_nxt = 1'b0;
            end
        end
        if (clr) begin
            valid_nxt = 1'b0;
            count_nxt = '0;
        end else if (wr_acc & ~rd_acc) begin
            count_nxt = count + cnt_width'(1);
        end else if (rd_acc & ~wr_acc) begin
            count_nxt = count - cnt_width'(1);
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[addr_width-1:0]] <= din;
        end
    end

    // Pointers, output register and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            valid        <= 1'b0;
            dout         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (almost_full_thresh == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + cnt_width'(1);
                end
                if (mem_rd) begin
                    rd_ptr <= rd_ptr + cnt_width'(1);
                end
            end
            if (mem_rd) begin
                dout <= mem[rd_ptr[addr_width-1:0]];
            end
            valid        <= valid_nxt;
            count        <= count_nxt;
            full         <= (32'(count_nxt) == fifo_depth);
            empty        <= fwft ? ~valid_nxt : (count_nxt == '0);
            almost_full  <= (32'(count_nxt) >= almost_full_thresh);
            almost_empty <= (32'(count_nxt) <= almost_empty_thresh);
            overflow     <= ~clr & (overflow | (wr_en & full));
            underflow    <= ~clr & (underflow | (rd_en & empty));
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus and are
// checked against a queue-based model, a vector table and directed sequences.
module tb_sync_fifo;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [5:0] s_count, f_count;

    int total  = 0;
    int passes = 0;

    // Reference model state
    logic [7:0] sq[$];
    logic [7:0] fq[$];
    logic [7:0] s_dout_m, f_dout_m;
    bit         s_ovf_m, s_udf_m, f_ovf_m, f_udf_m, fv;

    always #5 clk = ~clk;

    sync_fifo #(.data_width(8), .fifo_depth(DEPTH), .fwft(1'b0)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf));

    sync_fifo #(.data_width(8), .fifo_depth(DEPTH), .fwft(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        sq.delete(); fq.delete();
        s_dout_m = 8'h00; f_dout_m = 8'h00; fv = 0;
        s_ovf_m = 0; s_udf_m = 0; f_ovf_m = 0; f_udf_m = 0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state and inputs.
    task automatic model_step();
        bit sf, se, ff, fe, fhas;
        if (clr) begin
            sq.delete(); fq.delete(); fv = 0;
            s_ovf_m = 0; s_udf_m = 0; f_ovf_m = 0; f_udf_m = 0;
            return;
        end
        sf = (sq.size() == DEPTH);
        se = (sq.size() == 0);
        if (wr_en && sf) s_ovf_m = 1;
        if (rd_en && se) s_udf_m = 1;
        if (rd_en && !se) s_dout_m = sq.pop_front();
        if (wr_en && !sf) sq.push_back(din);

        ff   = ((fq.size() + int'(fv)) == DEPTH);
        fe   = !fv;
        fhas = (fq.size() > 0);
        if (wr_en && ff) f_ovf_m = 1;
        if (rd_en && fe) f_udf_m = 1;
        if (!fv || rd_en) begin
            if (fhas) begin
                f_dout_m = fq.pop_front();
                fv = 1;
            end else begin
                fv = 0;
            end
        end
        if (wr_en && !ff) fq.push_back(din);
    endtask

    task automatic compare_all();
        int sc, fc;
        sc = sq.size();
        fc = fq.size() + int'(fv);
        chk("std_count", int'(s_count), sc);
        chk("std_full", int'(s_full), int'(sc == DEPTH));
        chk("std_empty", int'(s_empty), int'(sc == 0));
        chk("std_af", int'(s_af), int'(sc >= AF));
        chk("std_ae", int'(s_ae), int'(sc <= AE));
        chk("std_dout", int'(s_dout), int'(s_dout_m));
        chk("std_ovf", int'(s_ovf), int'(s_ovf_m));
        chk("std_udf", int'(s_udf), int'(s_udf_m));
        chk("fwft_count", int'(f_count), fc);
        chk("fwft_full", int'(f_full), int'(fc == DEPTH));
        chk("fwft_empty", int'(f_empty), int'(!fv));
        chk("fwft_af", int'(f_af), int'(fc >= AF));
        chk("fwft_ae", int'(f_ae), int'(fc <= AE));
        chk("fwft_dout", int'(f_dout), int'(f_dout_m));
        chk("fwft_ovf", int'(f_ovf), int'(f_ovf_m));
        chk("fwft_udf", int'(f_udf), int'(f_udf_m));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1 compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1 compare_all();
        rst = 1'b0;
    endtask

    task automatic drive(input bit w, input bit r, input bit c, input logic [7:0] d);
        wr_en = w; rd_en = r; clr = c; din = d;
    endtask

    typedef struct {
        bit         wr, rd, clr;
        logic [7:0] din;
        int         s_cnt;
        bit         s_emp;
        logic [7:0] s_dout;
        bit         s_udf;
        int         f_cnt;
        bit         f_emp;
        logic [7:0] f_dout;
        bit         f_udf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1, 0, 0, 8'hA5, 1, 0, 8'h00, 0, 1, 1, 8'h00, 0};
        vecs[1]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 0, 1, 0, 8'hA5, 1};
        vecs[2]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 1, 8'hA5, 1};
        vecs[3]  = '{1, 0, 0, 8'h11, 1, 0, 8'hA5, 1, 1, 1, 8'hA5, 1};
        vecs[4]  = '{1, 0, 0, 8'h22, 2, 0, 8'hA5, 1, 2, 0, 8'h11, 1};
        vecs[5]  = '{0, 0, 0, 8'h00, 2, 0, 8'hA5, 1, 2, 0, 8'h11, 1};
        vecs[6]  = '{0, 1, 0, 8'h00, 1, 0, 8'h11, 1, 1, 0, 8'h22, 1};
        vecs[7]  = '{0, 1, 0, 8'h00, 0, 1, 8'h22, 1, 0, 1, 8'h22, 1};
        vecs[8]  = '{1, 0, 1, 8'h33, 0, 1, 8'h22, 0, 0, 1, 8'h22, 0};
        vecs[9]  = '{0, 0, 0, 8'h00, 0, 1, 8'h22, 0, 0, 1, 8'h22, 0};
        vecs[10] = '{1, 1, 0, 8'h44, 1, 0, 8'h22, 1, 1, 1, 8'h22, 1};
        vecs[11] = '{0, 0, 0, 8'h00, 1, 0, 8'h22, 1, 1, 0, 8'h44, 1};

        do_reset();

        // Table: standard latency, FWFT prefetch, underflow, clr-over-write.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            cycle();
            chk($sformatf("vec%0d_s_cnt", i), int'(s_count), vecs[i].s_cnt);
            chk($sformatf("vec%0d_s_emp", i), int'(s_empty), int'(vecs[i].s_emp));
            chk($sformatf("vec%0d_s_dout", i), int'(s_dout), int'(vecs[i].s_dout));
            chk($sformatf("vec%0d_s_udf", i), int'(s_udf), int'(vecs[i].s_udf));
            chk($sformatf("vec%0d_f_cnt", i), int'(f_count), vecs[i].f_cnt);
            chk($sformatf("vec%0d_f_emp", i), int'(f_empty), int'(vecs[i].f_emp));
            chk($sformatf("vec%0d_f_dout", i), int'(f_dout), int'(vecs[i].f_dout));
            chk($sformatf("vec%0d_f_udf", i), int'(f_udf), int'(vecs[i].f_udf));
        end

        // Fill 0x01..0x20, overflow, drain in order.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, 0, 8'(i));
            cycle();
            if (i == AF - 1) chk("af_below_thresh", int'(s_af), 0);
            if (i == AF) chk("af_at_thresh", int'(s_af), 1);
        end
        chk("fill_full", int'(s_full), 1);
        chk("fill_count", int'(s_count), DEPTH);
        chk("fill_fwft_full", int'(f_full), 1);
        drive(1, 0, 0, 8'hFF);
        cycle();
        chk("fill_overflow", int'(s_ovf), 1);
        chk("fill_count_after_ovf", int'(s_count), DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 1, 0, 8'h00);
            cycle();
            chk("drain_order", int'(s_dout), i);
        end
        chk("drain_empty", int'(s_empty), 1);
        chk("drain_fwft_empty", int'(f_empty), 1);

        // Full with continuous write+read: pointers wrap several times.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 8'(i));
            cycle();
        end
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 0, 8'(8'h80 + i));
            cycle();
        end
        chk("stream_count", int'(s_count), DEPTH - 1);

        // Flush at count 10 with overflow set (overflow from a prior fill).
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1, 0, 0, 8'(i));
            cycle();
        end
        for (int i = 0; i < DEPTH - 10; i++) begin
            drive(0, 1, 0, 8'h00);
            cycle();
        end
        chk("pre_clr_count", int'(s_count), 10);
        chk("pre_clr_ovf", int'(s_ovf), 1);
        drive(1, 0, 1, 8'h5A);
        cycle();
        chk("clr_count", int'(s_count), 0);
        chk("clr_empty", int'(s_empty), 1);
        chk("clr_ovf", int'(s_ovf), 0);
        drive(0, 0, 0, 8'h00);
        cycle();
        chk("clr_not_stored", int'(f_empty), 1);

        // Async reset between edges during a burst.
        for (int i = 0; i < 8; i++) begin
            drive(1, i > 3, 0, 8'(8'hC0 + i));
            cycle();
        end
        rst = 1'b1;
        #2;
        model_reset();
        chk("arst_s_count", int'(s_count), 0);
        chk("arst_s_empty", int'(s_empty), 1);
        chk("arst_s_dout", int'(s_dout), 0);
        chk("arst_f_empty", int'(f_empty), 1);
        chk("arst_f_dout", int'(f_dout), 0);
        chk("arst_f_count", int'(f_count), 0);
        drive(0, 0, 0, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic with varying write/read pressure and rare flushes.
        for (int ph = 0; ph < 10; ph++) begin
            int pw, pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 300; i++) begin
                drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                      $urandom_range(0, 199) == 0, 8'($urandom));
                cycle();
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
